pc_msg_dispatch: RTL and testbench
==================================

// Module: pc_msg_dispatch
// PURPOSE
//  Parametrised successor to the fixed two-way PC message split. Pops words from the PC->FPGA FWFT FIFO on bus_clk,
//  parses burst headers and routes payload to one of N_CH downstream channel FIFOs (ch0 = pixel stream, ch1 = DRAM coeff, ...).
//  Per-channel backpressure stalls only the word's own target channel; other traffic is not gated by unrelated full flags.
// PARAMETERS
//  XB_SIZE     32  PC message word width
//  N_CH        4   number of output channels (2..16)
//  LEN_BITS    4   burst length field width; burst = 1..2**LEN_BITS payload words
//  CNT_W       32  statistics counter width (PC_DISPATCH_STATS_EN only)
// PORTS
//  bus_clk         in   1             clock
//  reset           in   1             asynchronous, active-high
//  pc_msg_empty    in   1             PC FIFO empty; pc_msg valid when low
//  pc_msg          in   XB_SIZE       PC FIFO head word (FWFT)
//  pc_msg_ack      out  1             pop PC FIFO (combinational)
//  ch_almost_full  in   N_CH          per-channel almost_full; asserted with >=2 free entries remaining
//  ch_wren         out  N_CH          one-hot write strobe, registered
//  ch_data         out  XB_SIZE       shared write data, registered
//  ch_last         out  1             last payload word of burst; carries header E bit on that word
//  busy            out  1             burst in progress
//  error           out  1             sticky protocol error
//  stat_words      out  N_CH*CNT_W    per-channel words written (flattened, ch0 at LSB)
//  stat_stall      out  CNT_W         cycles with a word present but ack held low
// BEHAVIOUR
//  Header word: bit0=1, bit1=E, bits[2+:4]=channel, bits[8+:LEN_BITS]=length-1. Header is consumed, not forwarded.
//  Word with bit0=0 in IDLE is a stream word: forwarded to ch0, ch_last=0.
//  States: IDLE, BURST, ERROR. Reset -> IDLE; all outputs 0; counters 0; burst latch cleared.
//  target (comb): IDLE & bit0=0 -> ch0; IDLE & bit0=1 -> none (header needs no space); BURST -> latched channel.
//  pc_msg_ack = !pc_msg_empty && state!=ERROR && !(target valid && ch_almost_full[target]).
//  On ack, IDLE header: channel>=N_CH -> ERROR (word dropped, error=1); else latch ch, remaining=len, E; -> BURST.
//  On ack, BURST: ch_wren[ch]<=1, ch_data<=word, remaining-1; last word: ch_last<=E, -> IDLE.
//  Latency: accepted payload appears on ch_wren/ch_data the next bus_clk edge; ch_wren=0 on any cycle without ack.
//  Back-to-back: header may follow last payload immediately; a burst of L words occupies L+1 cycles with no bubble.
//  Length field 0 = single payload word (header and last word both in that burst).
//  Bit0 of payload words inside BURST is data, not parsed.
//  ERROR: ack held 0, no writes, error stays 1 until reset. busy = (state==BURST).
//  Reset mid-burst: burst abandoned, FSM -> IDLE; downstream sees no ch_last for that burst.
//  almost_full asserted while in BURST: stall without dropping; remaining count and channel latch held.
// CONFIGURATION
//  PC_DISPATCH_STATS_EN defined: stat_words[ch] +1 per ch_wren; stat_stall +1 per cycle with !pc_msg_empty && !pc_msg_ack
//    && state!=ERROR. Counters wrap modulo 2**CNT_W silently; reset clears them.
//  Not defined: stat_words and stat_stall tied to 0; no counter logic synthesised.
// STRUCTURE
//  Shared include xb_msg_defs.vh: header field offsets/widths (HDR_FLAG, HDR_E, HDR_CH_LSB, HDR_LEN_LSB), FSM encodings,
//    CH_PIXEL=0, CH_DRAM=1 constants; also used by testbench and host software headers.
//  Sub-module dispatch_stats (N_CH, CNT_W): counter bank instantiated only under PC_DISPATCH_STATS_EN.
//  log2 from function.v for state width.
// TESTING
//  1 Stream: 3 words bit0=0 (0x100,0x200,0x300), all not full -> ch_wren=0001 on 3 consecutive cycles, data in order, ch_last=0.
//  2 Burst: header ch1 len-1=7 E=1 + 8 payload -> 8 writes ch1, ch_last only on word 8; total 9 cycles; busy high 8 cycles.
//  3 Isolation: ch1 almost_full held, stream words to ch0 -> ch0 written every cycle; then ch1 header accepted, payload stalls,
//    release -> payload resumes with no loss/duplication; stat_stall = stalled cycles (STATS_EN build).
//  4 Bad channel: N_CH=4, header ch=5 -> error=1 next cycle, pc_msg_ack=0 forever, no ch_wren; reset clears error, IDLE.
//  5 Reset mid-burst: assert reset after 3 of 8 payload words -> outputs 0 immediately; next header parsed fresh, correct.
//  6 Stats wrap: CNT_W=4, 17 stream words -> stat_words[0]=1; without PC_DISPATCH_STATS_EN stats read 0.

Source files
------------

// File: rtl/pc_msg_dispatch_pkg.sv
// Shared definitions for the PC message dispatcher: header field layout,
// well-known channel numbers and FSM state encoding.
package pc_msg_dispatch_pkg;

    // Header word layout (bit0 flags a header; payload words inside a burst are not parsed)
    localparam int unsigned HDR_FLAG    = 0;
    localparam int unsigned HDR_E       = 1;
    localparam int unsigned HDR_CH_LSB  = 2;
    localparam int unsigned HDR_CH_W    = 4;
    localparam int unsigned HDR_LEN_LSB = 8;

    // Well-known channel assignments
    localparam int unsigned CH_PIXEL = 0;
    localparam int unsigned CH_DRAM  = 1;

    // Dispatcher FSM
    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERROR = 2'd2
    } disp_state_e;

endpackage

// File: rtl/pc_msg_dispatch_stats.sv
// Per-channel write counters and a stall-cycle counter for the dispatcher.
// Only instantiated when PC_DISPATCH_STATS_EN is defined. Counters wrap silently.
module dispatch_stats #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                    bus_clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         ch_wren,
    input  logic                    stall,
    output logic [N_CH*CNT_W-1:0]   stat_words,
    output logic [CNT_W-1:0]        stat_stall
);

    logic [CNT_W-1:0] words_cnt [N_CH];

    // Count one word per write strobe on each channel
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                words_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (ch_wren[i]) begin
                    words_cnt[i] <= words_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Count cycles where a word waited on backpressure
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            stat_stall <= '0;
        end else if (stall) begin
            stat_stall <= stat_stall + CNT_W'(1);
        end
    end

    // Flatten counters, ch0 at the LSB
    always_comb begin
        stat_words = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            stat_words[i*CNT_W +: CNT_W] = words_cnt[i];
        end
    end

endmodule

// File: rtl/pc_msg_dispatch.sv
// PC message dispatcher: pops the PC->FPGA FWFT FIFO, parses burst headers and
// routes payload words to one of N_CH channel FIFOs. Backpressure only stalls
// the word's own target channel. Optional counters under PC_DISPATCH_STATS_EN.
module pc_msg_dispatch
    import pc_msg_dispatch_pkg::*;
#(
    parameter int unsigned XB_SIZE  = 32,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned LEN_BITS = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                    bus_clk,
    input  logic                    reset,
    input  logic                    pc_msg_empty,
    input  logic [XB_SIZE-1:0]      pc_msg,
    output logic                    pc_msg_ack,
    input  logic [N_CH-1:0]         ch_almost_full,
    output logic [N_CH-1:0]         ch_wren,
    output logic [XB_SIZE-1:0]      ch_data,
    output logic                    ch_last,
    output logic                    busy,
    output logic                    error,
    output logic [N_CH*CNT_W-1:0]   stat_words,
    output logic [CNT_W-1:0]        stat_stall
);

    disp_state_e            state;
    disp_state_e            state_next;
    logic                   hdr_flag;
    logic                   hdr_e;
    logic [HDR_CH_W-1:0]    hdr_ch;
    logic [LEN_BITS-1:0]    hdr_len;
    logic                   hdr_ch_ok;
    logic [N_CH-1:0]        hdr_mask;
    logic [N_CH-1:0]        tgt_mask;
    logic [N_CH-1:0]        burst_mask;
    logic [LEN_BITS-1:0]    remaining;
    logic                   burst_e;
    logic                   ack;

    // Decode header fields of the FIFO head word
    always_comb begin
        hdr_flag  = pc_msg[HDR_FLAG];
        hdr_e     = pc_msg[HDR_E];
        hdr_ch    = pc_msg[HDR_CH_LSB +: HDR_CH_W];
        hdr_len   = pc_msg[HDR_LEN_LSB +: LEN_BITS];
        hdr_ch_ok = (32'(hdr_ch) < N_CH);
        hdr_mask  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            hdr_mask[i] = (hdr_ch == HDR_CH_W'(i));
        end
    end

    // FSM state register
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Target selection, pop decision and next state
    always_comb begin
        state_next = state;
        tgt_mask   = '0;
        ack        = 1'b0;
        case (state)
            ST_IDLE:  if (!hdr_flag) tgt_mask = N_CH'(1) << CH_PIXEL;
            ST_BURST: tgt_mask = burst_mask;
            default:  tgt_mask = '0;
        endcase
        ack = !pc_msg_empty && (state != ST_ERROR) && ((tgt_mask & ch_almost_full) == '0);
        if (ack) begin
            case (state)
                ST_IDLE:  if (hdr_flag) state_next = hdr_ch_ok ? ST_BURST : ST_ERROR;
                ST_BURST: if (remaining == '0) state_next = ST_IDLE;
                default:  state_next = state;
            endcase
        end
    end

    assign pc_msg_ack = ack;
    assign busy       = (state == ST_BURST);

    // Burst latch and registered channel write port
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            ch_wren    <= '0;
            ch_data    <= '0;
            ch_last    <= 1'b0;
            error      <= 1'b0;
            burst_mask <= '0;
            remaining  <= '0;
            burst_e    <= 1'b0;
        end else begin
            ch_wren <= '0;
            ch_last <= 1'b0;
            error   <= (state_next == ST_ERROR);
            if (ack && state == ST_IDLE) begin
                if (!hdr_flag) begin
                    ch_wren <= N_CH'(1) << CH_PIXEL;
                    ch_data <= pc_msg;
                end else if (hdr_ch_ok) begin
                    burst_mask <= hdr_mask;
                    remaining  <= hdr_len;
                    burst_e    <= hdr_e;
                end
            end else if (ack && state == ST_BURST) begin
                ch_wren   <= burst_mask;
                ch_data   <= pc_msg;
                remaining <= remaining - LEN_BITS'(1);
                ch_last   <= (remaining == '0) ? burst_e : 1'b0;
            end
        end
    end

`ifdef PC_DISPATCH_STATS_EN
    logic stall;

    // A present word held back by backpressure (not by the error lockout)
    assign stall = !pc_msg_empty && !ack && (state != ST_ERROR);

    dispatch_stats #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) u_stats (
        .bus_clk    (bus_clk),
        .reset      (reset),
        .ch_wren    (ch_wren),
        .stall      (stall),
        .stat_words (stat_words),
        .stat_stall (stat_stall)
    );
`else
    assign stat_words = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_pc_msg_dispatch.sv
// Directed self-checking bench for pc_msg_dispatch (N_CH=4, CNT_W=4).
// Statistics expectations follow PC_DISPATCH_STATS_EN when it is defined.
module tb_pc_msg_dispatch;

`ifdef PC_DISPATCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        bus_clk = 1'b0;
    logic        reset;
    logic        pc_msg_empty;
    logic [31:0] pc_msg;
    logic        pc_msg_ack;
    logic [3:0]  ch_almost_full;
    logic [3:0]  ch_wren;
    logic [31:0] ch_data;
    logic        ch_last;
    logic        busy;
    logic        error;
    logic [15:0] stat_words;
    logic [3:0]  stat_stall;

    int errors = 0;
    int checks = 0;

    pc_msg_dispatch #(
        .XB_SIZE (32),
        .N_CH    (4),
        .LEN_BITS(4),
        .CNT_W   (4)
    ) dut (
        .bus_clk        (bus_clk),
        .reset          (reset),
        .pc_msg_empty   (pc_msg_empty),
        .pc_msg         (pc_msg),
        .pc_msg_ack     (pc_msg_ack),
        .ch_almost_full (ch_almost_full),
        .ch_wren        (ch_wren),
        .ch_data        (ch_data),
        .ch_last        (ch_last),
        .busy           (busy),
        .error          (error),
        .stat_words     (stat_words),
        .stat_stall     (stat_stall)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic cyc();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic present(input logic [31:0] w);
        pc_msg_empty = 1'b0;
        pc_msg       = w;
        #1;
    endtask

    task automatic rst_pulse();
        pc_msg_empty   = 1'b1;
        ch_almost_full = 4'b0000;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_msg_empty = 1'b1; pc_msg = 32'h0; ch_almost_full = 4'b0000;
        repeat (2) cyc();
        checks++;
        if ({ch_wren, ch_last, busy, error, pc_msg_ack} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=00000000", {ch_wren, ch_last, busy, error, pc_msg_ack});
        end
        checks++;
        if (ch_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", ch_data); end
        checks++;
        if ({stat_words, stat_stall} !== 20'h0) begin
            errors++; $display("FAIL reset_stats got=%h exp=0", {stat_words, stat_stall});
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            present(32'h100 * (k + 1));
            checks++;
            if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL stream_ack k=%0d got=%b exp=1", k, pc_msg_ack); end
            cyc();
            checks++;
            if (ch_wren !== 4'b0001 || ch_data !== 32'h100 * (k + 1) || ch_last !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL stream_write k=%0d got wren=%b data=%h last=%b busy=%b exp wren=0001 data=%h last=0 busy=0",
                                   k, ch_wren, ch_data, ch_last, busy, 32'h100 * (k + 1));
            end
        end
        pc_msg_empty = 1'b1;
        cyc();
        checks++;
        if (ch_wren !== 4'b0000) begin errors++; $display("FAIL stream_idle got=%b exp=0000", ch_wren); end
    endtask

    task automatic test_burst();
        int busy_cnt = 0;
        present(32'h0000_0707);
        checks++;
        if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL burst_hdr_ack got=%b exp=1", pc_msg_ack); end
        cyc();
        checks++;
        if (ch_wren !== 4'b0000 || busy !== 1'b1) begin
            errors++; $display("FAIL burst_hdr got wren=%b busy=%b exp wren=0000 busy=1", ch_wren, busy);
        end
        if (busy) busy_cnt++;
        for (int k = 0; k < 8; k++) begin
            present(32'hC0DE_0000 | 32'(k));
            checks++;
            if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL burst_ack k=%0d got=%b exp=1", k, pc_msg_ack); end
            cyc();
            checks++;
            if (ch_wren !== 4'b0010 || ch_data !== (32'hC0DE_0000 | 32'(k)) || ch_last !== (k == 7)) begin
                errors++; $display("FAIL burst_write k=%0d got wren=%b data=%h last=%b exp wren=0010 data=%h last=%b",
                                   k, ch_wren, ch_data, ch_last, 32'hC0DE_0000 | 32'(k), (k == 7));
            end
            if (k < 7 && busy) busy_cnt++;
        end
        checks++;
        if (busy !== 1'b0 || busy_cnt != 8) begin
            errors++; $display("FAIL burst_busy got busy=%b cycles=%0d exp busy=0 cycles=8", busy, busy_cnt);
        end
        pc_msg_empty = 1'b1;
        cyc();
        checks++;
        if (ch_wren !== 4'b0000) begin errors++; $display("FAIL burst_idle got=%b exp=0000", ch_wren); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w  [6] = '{32'h0000_000B, 32'h55AA_0001, 32'h0000_010D,
                                32'h1234_5677, 32'h89AB_CDEF, 32'h0000_0F00};
        logic [3:0]  ew [6] = '{4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0001};
        logic        el [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            present(w[i]);
            checks++;
            if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack i=%0d got=%b exp=1", i, pc_msg_ack); end
            cyc();
            checks++;
            if (ch_wren !== ew[i] || ch_last !== el[i] || (ew[i] != 4'b0000 && ch_data !== w[i])) begin
                errors++; $display("FAIL b2b_write i=%0d got wren=%b last=%b data=%h exp wren=%b last=%b data=%h",
                                   i, ch_wren, ch_last, ch_data, ew[i], el[i], w[i]);
            end
        end
        pc_msg_empty = 1'b1;
        cyc();
    endtask

    task automatic test_isolation();
        rst_pulse();
        ch_almost_full = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            present(32'h0001_0000 + 32'(k * 16));
            checks++;
            if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL iso_stream_ack k=%0d got=%b exp=1", k, pc_msg_ack); end
            cyc();
            checks++;
            if (ch_wren !== 4'b0001 || ch_data !== 32'h0001_0000 + 32'(k * 16)) begin
                errors++; $display("FAIL iso_stream_write k=%0d got wren=%b data=%h exp wren=0001 data=%h",
                                   k, ch_wren, ch_data, 32'h0001_0000 + 32'(k * 16));
            end
        end
        present(32'h0000_0205);
        checks++;
        if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL iso_hdr_ack got=%b exp=1", pc_msg_ack); end
        cyc();
        present(32'hDEAD_0001);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (pc_msg_ack !== 1'b0) begin errors++; $display("FAIL iso_stall_ack s=%0d got=%b exp=0", s, pc_msg_ack); end
            cyc();
            checks++;
            if (ch_wren !== 4'b0000 || busy !== 1'b1) begin
                errors++; $display("FAIL iso_stall s=%0d got wren=%b busy=%b exp wren=0000 busy=1", s, ch_wren, busy);
            end
        end
        ch_almost_full = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            present(32'hDEAD_0001 + 32'(k * 16));
            checks++;
            if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL iso_resume_ack k=%0d got=%b exp=1", k, pc_msg_ack); end
            cyc();
            checks++;
            if (ch_wren !== 4'b0010 || ch_data !== 32'hDEAD_0001 + 32'(k * 16) || ch_last !== 1'b0) begin
                errors++; $display("FAIL iso_resume k=%0d got wren=%b data=%h last=%b exp wren=0010 data=%h last=0",
                                   k, ch_wren, ch_data, ch_last, 32'hDEAD_0001 + 32'(k * 16));
            end
        end
        pc_msg_empty = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL iso_done_busy got=%b exp=0", busy); end
        checks++;
        if (stat_words !== (STATS_ON ? 16'h0034 : 16'h0000)) begin
            errors++; $display("FAIL iso_stat_words got=%h exp=%h", stat_words, STATS_ON ? 16'h0034 : 16'h0000);
        end
        checks++;
        if (stat_stall !== (STATS_ON ? 4'd3 : 4'd0)) begin
            errors++; $display("FAIL iso_stat_stall got=%0d exp=%0d", stat_stall, STATS_ON ? 3 : 0);
        end
    endtask

    task automatic test_bad_channel();
        present(32'h0000_0015);
        checks++;
        if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL bad_hdr_ack got=%b exp=1", pc_msg_ack); end
        cyc();
        checks++;
        if (error !== 1'b1 || ch_wren !== 4'b0000) begin
            errors++; $display("FAIL bad_error got error=%b wren=%b exp error=1 wren=0000", error, ch_wren);
        end
        present(32'h0000_0200);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (pc_msg_ack !== 1'b0) begin errors++; $display("FAIL bad_lock_ack s=%0d got=%b exp=0", s, pc_msg_ack); end
            cyc();
            checks++;
            if (ch_wren !== 4'b0000 || error !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL bad_lock s=%0d got wren=%b error=%b busy=%b exp wren=0000 error=1 busy=0",
                                   s, ch_wren, error, busy);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL bad_reset_clear got=%b exp=0", error); end
        reset = 1'b0;
        #1;
        checks++;
        if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL bad_recover_ack got=%b exp=1", pc_msg_ack); end
        cyc();
        checks++;
        if (ch_wren !== 4'b0001 || ch_data !== 32'h0000_0200) begin
            errors++; $display("FAIL bad_recover got wren=%b data=%h exp wren=0001 data=00000200", ch_wren, ch_data);
        end
        pc_msg_empty = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        present(32'h0000_0707);
        cyc();
        for (int k = 0; k < 3; k++) begin
            present(32'h7700_0000 + 32'(k));
            cyc();
            checks++;
            if (ch_wren !== 4'b0010 || ch_data !== 32'h7700_0000 + 32'(k)) begin
                errors++; $display("FAIL mid_write k=%0d got wren=%b data=%h exp wren=0010 data=%h",
                                   k, ch_wren, ch_data, 32'h7700_0000 + 32'(k));
            end
        end
        present(32'h7700_0003);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({ch_wren, ch_last, busy, error} !== 7'b0 || ch_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset got wren=%b last=%b busy=%b error=%b data=%h exp all zero",
                               ch_wren, ch_last, busy, error, ch_data);
        end
        reset = 1'b0;
        #1;
        present(32'h0000_010B);
        checks++;
        if (pc_msg_ack !== 1'b1) begin errors++; $display("FAIL mid_hdr_ack got=%b exp=1", pc_msg_ack); end
        cyc();
        checks++;
        if (busy !== 1'b1 || ch_wren !== 4'b0000) begin
            errors++; $display("FAIL mid_hdr got busy=%b wren=%b exp busy=1 wren=0000", busy, ch_wren);
        end
        for (int k = 0; k < 2; k++) begin
            present(32'h6600_0000 + 32'(k));
            cyc();
            checks++;
            if (ch_wren !== 4'b0100 || ch_data !== 32'h6600_0000 + 32'(k) || ch_last !== (k == 1)) begin
                errors++; $display("FAIL mid_fresh k=%0d got wren=%b data=%h last=%b exp wren=0100 data=%h last=%b",
                                   k, ch_wren, ch_data, ch_last, 32'h6600_0000 + 32'(k), (k == 1));
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_done_busy got=%b exp=0", busy); end
        pc_msg_empty = 1'b1;
        cyc();
    endtask

    task automatic test_stats_wrap();
        rst_pulse();
        for (int k = 0; k < 17; k++) begin
            present(32'h100 * (k + 1));
            cyc();
        end
        checks++;
        if (ch_wren !== 4'b0001 || ch_data !== 32'h0000_1100) begin
            errors++; $display("FAIL wrap_last got wren=%b data=%h exp wren=0001 data=00001100", ch_wren, ch_data);
        end
        pc_msg_empty = 1'b1;
        cyc();
        checks++;
        if (stat_words !== (STATS_ON ? 16'h0001 : 16'h0000) || stat_stall !== 4'd0) begin
            errors++; $display("FAIL wrap_stats got words=%h stall=%0d exp words=%h stall=0",
                               stat_words, stat_stall, STATS_ON ? 16'h0001 : 16'h0000);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_burst();
        test_back_to_back();
        test_isolation();
        test_bad_channel();
        test_reset_mid_burst();
        test_stats_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Run-away guard
    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
